// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for the word UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;
    localparam int   DEF_CLKS_PER_BIT = 868;
    localparam int   BYTES_PER_WORD   = 4;
    localparam int   DATA_BITS        = 8;
    localparam int   WORD_W           = BYTES_PER_WORD * DATA_BITS;
    localparam int   IDX_W            = $clog2(BYTES_PER_WORD);
    localparam logic IDLE_LEVEL       = 1'b1;
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: single-byte 8N1 transmitter that can chain the next byte straight out of its stop bit
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_start,
    input  logic [DATA_BITS-1:0] byte_data,
    output logic                 tx,
    output logic                 byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    state_t               state;
    logic [CW-1:0]        baud;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 wrap;
    logic                 last_bit;
    assign wrap      = baud == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = bit_idx == BW'(DATA_BITS - 1);
    assign byte_done = state == STOP && wrap;
    // frame sequencer: a start request in the last stop-bit cycle begins the next start bit with no gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= IDLE_LEVEL;
        end else if (byte_start && (state == IDLE || byte_done)) begin
            state   <= START;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= byte_data;
            tx      <= 1'b0;
        end else if (state != IDLE) begin
            baud <= wrap ? '0 : baud + 1'b1;
            if (wrap) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    DATA: begin
                        state   <= last_bit ? STOP : DATA;
                        tx      <= last_bit ? IDLE_LEVEL : shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/word_uart_tx.sv
// word_uart_tx: sends a 32-bit word as four back-to-back 8N1 frames, LSB byte first
module word_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [WORD_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_dataready
);
    logic [WORD_W-1:0]    word;
    logic [IDX_W-1:0]     idx;
    logic                 accept;
    logic                 last;
    logic                 advance;
    logic                 byte_done;
    logic                 byte_start;
    logic [DATA_BITS-1:0] byte_data;
    assign accept     = tx_start && !tx_busy;
    assign last       = byte_done && idx == IDX_W'(BYTES_PER_WORD - 1);
    assign advance    = byte_done && !last;
    assign byte_start = accept || advance;
    assign byte_data  = accept ? tx_data[DATA_BITS-1:0] : word[2*DATA_BITS-1:DATA_BITS];
    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_start(byte_start),
        .byte_data (byte_data),
        .tx        (tx),
        .byte_done (byte_done)
    );
    // word handshake: low byte of word is always the byte on the line, shifted down as each frame ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word         <= '0;
            idx          <= '0;
            tx_busy      <= 1'b0;
            tx_dataready <= 1'b0;
        end else begin
            tx_dataready <= last;
            if (accept) begin
                word    <= tx_data;
                idx     <= '0;
                tx_busy <= 1'b1;
            end else if (advance) begin
                word <= word >> DATA_BITS;
                idx  <= idx + 1'b1;
            end else if (last) begin
                tx_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_word_uart_tx.sv
// tb_word_uart_tx: randomized self-checking bench against a per-cycle line model of the word transmitter
module tb_word_uart_tx;
    localparam int CPB      = 4;
    localparam int FRAME    = 10 * CPB;
    localparam int WORD_CYC = 4 * FRAME;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_start = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx;
    logic        tx_busy;
    logic        tx_dataready;
    int          vectors = 0;
    int          errors = 0;
    int          pulses = 0;

    word_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_dataready(tx_dataready)
    );

    always #5 clk = ~clk;

    // expected line level k cycles after the accepting edge: start=0, 8 data bits LSB first, stop=1
    function automatic logic exp_tx(input logic [31:0] w, input int k);
        int b;
        int p;
        b = k / FRAME;
        p = (k % FRAME) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[b*8 + p - 1];
    endfunction

    task automatic test_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_dataready !== 1'b0) begin
                errors++;
                $display("FAIL idle: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0", tx, tx_busy, tx_dataready);
            end
        end
    endtask

    // caller has tx_start=1/tx_data=w set for the accepting edge; returns at the negedge of the DONE cycle
    task automatic run_word(input logic [31:0] w, input int rej_k, input logic [31:0] rej_w,
                            input logic chain, input logic [31:0] next_w);
        logic [7:0] acc;
        int p;
        acc = '0;
        @(negedge clk);
        for (int k = 0; k < WORD_CYC; k++) begin
            vectors++;
            if (tx !== exp_tx(w, k) || tx_busy !== 1'b1 || tx_dataready !== 1'b0) begin
                errors++;
                $display("FAIL line word=%h k=%0d: tx=%b busy=%b rdy=%b, required tx=%b busy=1 rdy=0",
                         w, k, tx, tx_busy, tx_dataready, exp_tx(w, k));
            end
            p = (k % FRAME) / CPB;
            if (k % CPB == CPB / 2 && p >= 1 && p <= 8) acc[p-1] = tx;
            if (k % FRAME == FRAME - 2) begin
                vectors++;
                if (acc !== w[(k/FRAME)*8 +: 8]) begin
                    errors++;
                    $display("FAIL byte word=%h idx=%0d: decoded %h, required %h", w, k / FRAME, acc, w[(k/FRAME)*8 +: 8]);
                end
            end
            tx_start = (k == rej_k);
            tx_data  = (k == rej_k) ? rej_w : $urandom;
            @(negedge clk);
        end
        vectors++;
        if (tx_dataready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL done word=%h: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=1", w, tx, tx_busy, tx_dataready);
        end
        if (tx_dataready === 1'b1) pulses++;
        tx_start = chain;
        tx_data  = next_w;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_start = 1'($urandom_range(1));
            tx_data  = $urandom;
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_dataready !== 1'b0) begin
                errors++;
                $display("FAIL reset: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0", tx, tx_busy, tx_dataready);
            end
        end
        tx_start = 1'b0;
        rst = 1'b1;
        test_idle(2);
    endtask

    task automatic test_single();
        tx_start = 1'b1;
        tx_data  = 32'hA5C30F81;
        run_word(32'hA5C30F81, -1, '0, 1'b0, '0);
        test_idle(3);
    endtask

    task automatic test_busy_reject();
        tx_start = 1'b1;
        tx_data  = 32'hA5C30F81;
        run_word(32'hA5C30F81, 50, 32'h12345678, 1'b0, '0);
        test_idle(3);
    endtask

    task automatic test_back_to_back();
        tx_start = 1'b1;
        tx_data  = 32'hFFFFFFFF;
        run_word(32'hFFFFFFFF, -1, '0, 1'b1, 32'h00000000);
        run_word(32'h00000000, -1, '0, 1'b1, 32'h3C3C_5AA5);
        run_word(32'h3C3C_5AA5, -1, '0, 1'b0, '0);
        test_idle(2);
    endtask

    task automatic test_reset_mid();
        tx_start = 1'b1;
        tx_data  = 32'h5A00C3F0;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        vectors++;
        if (tx !== exp_tx(32'h5A00C3F0, 50)) begin
            errors++;
            $display("FAIL pre_abort: tx=%b, required %b", tx, exp_tx(32'h5A00C3F0, 50));
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_dataready !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: tx=%b busy=%b rdy=%b, required tx=1 busy=0 rdy=0", tx, tx_busy, tx_dataready);
        end
        test_idle(3);
        rst = 1'b1;
        test_idle(3);
        tx_start = 1'b1;
        tx_data  = 32'hDEADBEEF;
        run_word(32'hDEADBEEF, -1, '0, 1'b0, '0);
        test_idle(2);
    endtask

    task automatic test_debug_loop();
        logic [31:0] w;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 57; i++) begin
            w = $urandom;
            tx_start = 1'b1;
            tx_data  = w;
            run_word(w, -1, '0, 1'b0, '0);
            test_idle(int'($urandom_range(0, 3)));
        end
        vectors++;
        if (pulses - p0 !== 57) begin
            errors++;
            $display("FAIL loop_pulses: saw %0d, required 57", pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_debug_loop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
